// File: rtl/l1_mem_arbiter.sv
// Serialises L1 icache fills and dcache fills/write-backs onto a single L2 line port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the dcache has fixed priority.
module l1_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_pmem_read,
  input  logic [ADDR_W-1:0] ic_pmem_address,
  output logic [LINE_W-1:0] ic_pmem_rdata,
  output logic              ic_pmem_resp,
  input  logic              dc_pmem_read,
  input  logic              dc_pmem_write,
  input  logic [ADDR_W-1:0] dc_pmem_address,
  input  logic [LINE_W-1:0] dc_pmem_wdata,
  output logic [LINE_W-1:0] dc_pmem_rdata,
  output logic              dc_pmem_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

  state_t            r_state;
  state_t            w_next_state;
  logic              w_dc_req;
  logic              w_grant_i;
  logic              w_grant_d;
  logic [ADDR_W-1:0] w_ic_addr_aligned;
  logic [ADDR_W-1:0] w_dc_addr_aligned;

  logic              r_l2_read;
  logic              r_l2_write;
  logic [ADDR_W-1:0] r_l2_address;
  logic [LINE_W-1:0] r_l2_wdata;
  logic [LINE_W-1:0] r_ic_line;
  logic [LINE_W-1:0] r_dc_line;
  logic              r_ic_resp;
  logic              r_dc_resp;

`ifdef ARB_ROUND_ROBIN_EN
  logic              r_last_grant_d;
`endif

  assign w_dc_req          = dc_pmem_read | dc_pmem_write;
  assign w_ic_addr_aligned = ic_pmem_address & ALIGN_MASK;
  assign w_dc_addr_aligned = dc_pmem_address & ALIGN_MASK;

  // Grant decision, only meaningful while idle
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == IDLE) begin
      if (ic_pmem_read && w_dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (r_last_grant_d) begin
          w_grant_i = 1'b1;
        end else begin
          w_grant_d = 1'b1;
        end
`else
        // MEM-stage access belongs to an older instruction than the fetch
        w_grant_d = 1'b1;
`endif
      end else if (w_dc_req) begin
        w_grant_d = 1'b1;
      end else if (ic_pmem_read) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
      end
    end else begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next_state = BUSY_D;
        end else if (w_grant_i) begin
          w_next_state = BUSY_I;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (l2_resp) begin
          w_next_state = RESP;
        end else begin
          w_next_state = r_state;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State, latched request, L2 handshake and client response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_l2_read    <= 1'b0;
      r_l2_write   <= 1'b0;
      r_l2_address <= {ADDR_W{1'b0}};
      r_l2_wdata   <= {LINE_W{1'b0}};
      r_ic_line    <= {LINE_W{1'b0}};
      r_dc_line    <= {LINE_W{1'b0}};
      r_ic_resp    <= 1'b0;
      r_dc_resp    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant_d <= 1'b1;
`endif
    end else begin
      r_state   <= w_next_state;
      r_ic_resp <= 1'b0;
      r_dc_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            // Read and write together is treated as a write
            r_l2_read    <= ~dc_pmem_write;
            r_l2_write   <= dc_pmem_write;
            r_l2_address <= w_dc_addr_aligned;
            r_l2_wdata   <= dc_pmem_wdata;
          end else if (w_grant_i) begin
            r_l2_read    <= 1'b1;
            r_l2_write   <= 1'b0;
            r_l2_address <= w_ic_addr_aligned;
          end else begin
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (w_grant_i || w_grant_d) begin
            r_last_grant_d <= w_grant_d;
          end
`endif
        end
        BUSY_I, BUSY_D: begin
          if (l2_resp) begin
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            if (r_state == BUSY_D) begin
              r_dc_line <= l2_rdata;
              r_dc_resp <= 1'b1;
            end else begin
              r_ic_line <= l2_rdata;
              r_ic_resp <= 1'b1;
            end
          end
        end
        RESP: begin
          r_l2_read  <= 1'b0;
          r_l2_write <= 1'b0;
        end
        default: begin
          r_l2_read  <= 1'b0;
          r_l2_write <= 1'b0;
        end
      endcase
    end
  end

  assign l2_read       = r_l2_read;
  assign l2_write      = r_l2_write;
  assign l2_address    = r_l2_address;
  assign l2_wdata      = r_l2_wdata;
  assign ic_pmem_rdata = r_ic_line;
  assign ic_pmem_resp  = r_ic_resp;
  assign dc_pmem_rdata = r_dc_line;
  assign dc_pmem_resp  = r_dc_resp;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed self-checking bench for l1_mem_arbiter; honours ARB_ROUND_ROBIN_EN for arbitration-order expectations.
module tb_l1_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_pmem_read;
  logic [ADDR_W-1:0] ic_pmem_address;
  logic [LINE_W-1:0] ic_pmem_rdata;
  logic              ic_pmem_resp;
  logic              dc_pmem_read;
  logic              dc_pmem_write;
  logic [ADDR_W-1:0] dc_pmem_address;
  logic [LINE_W-1:0] dc_pmem_wdata;
  logic [LINE_W-1:0] dc_pmem_rdata;
  logic              dc_pmem_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_WB = 128'h0123456789ABCDEF0123456789ABCDEF;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ic_pmem_read    (ic_pmem_read),
    .ic_pmem_address (ic_pmem_address),
    .ic_pmem_rdata   (ic_pmem_rdata),
    .ic_pmem_resp    (ic_pmem_resp),
    .dc_pmem_read    (dc_pmem_read),
    .dc_pmem_write   (dc_pmem_write),
    .dc_pmem_address (dc_pmem_address),
    .dc_pmem_wdata   (dc_pmem_wdata),
    .dc_pmem_rdata   (dc_pmem_rdata),
    .dc_pmem_resp    (dc_pmem_resp),
    .l2_read         (l2_read),
    .l2_write        (l2_write),
    .l2_address      (l2_address),
    .l2_wdata        (l2_wdata),
    .l2_rdata        (l2_rdata),
    .l2_resp         (l2_resp)
  );

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Simultaneous-request round: grant, one-cycle L2 reply, response pulse, client drops
  task automatic serve_one(input string tag, input logic exp_d, input logic [LINE_W-1:0] data);
    step();
    check_val({tag, "_addr"}, l2_address, exp_d ? 16'h4000 : 16'h2000);
    check_val({tag, "_l2rd"}, l2_read, 1'b1);
    l2_rdata = data;
    l2_resp  = 1'b1;
    step();
    l2_resp = 1'b0;
    check_val({tag, "_icresp"}, ic_pmem_resp, !exp_d);
    check_val({tag, "_dcresp"}, dc_pmem_resp, exp_d);
    check_val({tag, "_rdata"}, exp_d ? dc_pmem_rdata : ic_pmem_rdata, data);
    if (exp_d) dc_pmem_read = 1'b0;
    else       ic_pmem_read = 1'b0;
    step();
    check_val({tag, "_resp_drop"}, {ic_pmem_resp, dc_pmem_resp}, 2'b00);
  endtask

  initial begin
    logic first_d;
    reset_n         = 1'b0;
    ic_pmem_read    = 1'b1;
    ic_pmem_address = 16'hFFFF;
    dc_pmem_read    = 1'b1;
    dc_pmem_write   = 1'b1;
    dc_pmem_address = 16'hFFFF;
    dc_pmem_wdata   = {LINE_W{1'b1}};
    l2_rdata        = {LINE_W{1'b1}};
    l2_resp         = 1'b1;

    // Reset held 3 cycles with everything asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_ctl", {l2_read, l2_write, ic_pmem_resp, dc_pmem_resp}, 4'b0000);
      check_val("rst_addr", l2_address, 16'h0000);
      check_val("rst_wdata", l2_wdata, {LINE_W{1'b0}});
      check_val("rst_icrd", ic_pmem_rdata, {LINE_W{1'b0}});
      check_val("rst_dcrd", dc_pmem_rdata, {LINE_W{1'b0}});
    end

    // icache fill, L2 answers after 4 busy cycles
    reset_n         = 1'b1;
    l2_resp         = 1'b0;
    dc_pmem_read    = 1'b0;
    dc_pmem_write   = 1'b0;
    ic_pmem_address = 16'h1236;
    step();
    check_val("ic_grant_rd", {l2_read, l2_write}, 2'b10);
    check_val("ic_addr", l2_address, 16'h1230);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("ic_busy", {l2_read, ic_pmem_resp, dc_pmem_resp}, 3'b100);
    end
    l2_rdata = LINE_A5;
    l2_resp  = 1'b1;
    step();
    l2_resp      = 1'b0;
    ic_pmem_read = 1'b0;
    check_val("ic_done", {l2_read, ic_pmem_resp, dc_pmem_resp}, 3'b010);
    check_val("ic_rdata", ic_pmem_rdata, LINE_A5);
    step();
    check_val("ic_pulse_end", {ic_pmem_resp, dc_pmem_resp}, 2'b00);

    // dcache write-back with inputs perturbed while in flight
    dc_pmem_write   = 1'b1;
    dc_pmem_address = 16'h8010;
    dc_pmem_wdata   = LINE_WB;
    step();
    check_val("wb_grant", {l2_read, l2_write}, 2'b01);
    check_val("wb_addr", l2_address, 16'h8010);
    check_val("wb_wdata", l2_wdata, LINE_WB);
    dc_pmem_wdata   = ~LINE_WB;
    dc_pmem_address = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("wb_hold_ctl", {l2_read, l2_write, dc_pmem_resp}, 3'b010);
      check_val("wb_hold_addr", l2_address, 16'h8010);
      check_val("wb_hold_wdata", l2_wdata, LINE_WB);
    end
    l2_rdata = {LINE_W{1'b0}};
    l2_resp  = 1'b1;
    step();
    l2_resp       = 1'b0;
    dc_pmem_write = 1'b0;
    check_val("wb_done", {l2_read, l2_write, ic_pmem_resp, dc_pmem_resp}, 4'b0001);
    check_val("wb_ic_hold", ic_pmem_rdata, LINE_A5);
    step();
    check_val("wb_pulse_end", dc_pmem_resp, 1'b0);

    // Simultaneous reads, three rounds
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    for (int r = 0; r < 3; r++) begin
      ic_pmem_read    = 1'b1;
      ic_pmem_address = 16'h2004;
      dc_pmem_read    = 1'b1;
      dc_pmem_address = 16'h400F;
      serve_one($sformatf("arb%0d_first", r), first_d, {4{32'h1000_0000 + 32'(r)}});
      serve_one($sformatf("arb%0d_second", r), !first_d, {4{32'h2000_0000 + 32'(r)}});
    end

    // dcache read and write together is a write
    dc_pmem_read    = 1'b1;
    dc_pmem_write   = 1'b1;
    dc_pmem_address = 16'h3338;
    dc_pmem_wdata   = LINE_WB;
    step();
    check_val("rw_as_write", {l2_read, l2_write}, 2'b01);
    check_val("rw_addr", l2_address, 16'h3330);
    l2_resp = 1'b1;
    step();
    l2_resp       = 1'b0;
    dc_pmem_read  = 1'b0;
    dc_pmem_write = 1'b0;
    check_val("rw_resp", {ic_pmem_resp, dc_pmem_resp}, 2'b01);
    step();

    // Reset during BUSY_D
    dc_pmem_read    = 1'b1;
    dc_pmem_address = 16'h5557;
    step();
    check_val("mr_grant", {l2_read, l2_address}, {1'b1, 16'h5550});
    step();
    reset_n = 1'b0;
    step();
    check_val("mr_l2rd_low", {l2_read, l2_write, dc_pmem_resp}, 3'b000);
    check_val("mr_addr_clr", l2_address, 16'h0000);
    check_val("mr_dcrd_clr", dc_pmem_rdata, {LINE_W{1'b0}});
    reset_n      = 1'b1;
    dc_pmem_read = 1'b0;
    l2_rdata     = LINE_A5;
    l2_resp      = 1'b1;
    // Late/spurious l2_resp held two cycles while idle
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("spur_idle", {l2_read, l2_write, ic_pmem_resp, dc_pmem_resp}, 4'b0000);
    end
    l2_resp = 1'b0;

    // Held l2_resp yields one response pulse
    ic_pmem_read    = 1'b1;
    ic_pmem_address = 16'h0ABC;
    step();
    check_val("held_addr", l2_address, 16'h0AB0);
    l2_rdata = {8{16'hBEEF}};
    l2_resp  = 1'b1;
    step();
    ic_pmem_read = 1'b0;
    check_val("held_pulse", ic_pmem_resp, 1'b1);
    check_val("held_rdata", ic_pmem_rdata, {8{16'hBEEF}});
    step();
    check_val("held_no_second", ic_pmem_resp, 1'b0);
    step();
    check_val("held_idle", {l2_read, ic_pmem_resp, dc_pmem_resp}, 3'b000);
    l2_resp = 1'b0;
    step();
    check_val("held_quiet", {l2_read, ic_pmem_resp}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
